write_queue: RTL and testbench
==============================

WRITE_QUEUE -- requirements
Module: write_queue

Interface
REQ-001 Parameter LINE_WIDTH, default 256, cache line width in bits; SHALL be a multiple of 32 and a power of two.
REQ-002 Parameter DEPTH, default 4, number of queued dirty lines; SHALL be a power of two and at least 2.
REQ-003 Parameter AWID, default 1, constant driven on AWID/WID.
REQ-004 Derived values: LINE_BYTE_OFFSET = log2(LINE_WIDTH/8); LABEL_WIDTH = 32 - LINE_BYTE_OFFSET; BURST_LIMIT = LINE_WIDTH/32 - 1.
REQ-005 Port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-006 Port rst, input, 1, asynchronous active-low reset; state is reset while rst = 0.
REQ-007 Port axi3_wr_if, axi3_wr_if.master, -, AXI3 write address, write data and write response channels.
REQ-008 Port pline, input, LABEL_WIDTH+LINE_WIDTH, line to enqueue: label in the upper LABEL_WIDTH bits, data in the lower LINE_WIDTH bits.
REQ-009 Ports push (input, 1) / pushed (output, 1) / full (output, 1): enqueue request / enqueue accepted this cycle / no free slot.
REQ-010 Ports query_label (input, LABEL_WIDTH) / query_found (output, 1) / query_rdata (output, LINE_WIDTH): lookup key / hit / hit data.
REQ-011 Ports write (input, 1) / query_wdata (input, LINE_WIDTH) / query_wbe (input, LINE_WIDTH/8) / written (output, 1): byte-masked update request of the hit entry / update accepted.
REQ-012 Port empty, output, 1: no entry is queued and no burst is in flight.

Function
REQ-013 Storage SHALL be a circular FIFO of DEPTH {valid, label, data} entries with a head pointer, a tail pointer and a count in 0..DEPTH; pointers wrap modulo DEPTH.
REQ-014 full SHALL equal (count == DEPTH); empty SHALL equal (count == 0 && state == WQ_IDLE).
REQ-015 A merge target is a valid entry with a matching label that is not the draining head. If push = 1 and a merge target exists, the push SHALL overwrite that entry's data, set pushed = 1 even when full = 1, and leave the count unchanged.
REQ-016 Otherwise, pushed SHALL equal push & ~full; an accepted push writes the tail entry at the clock edge and advances the tail.
REQ-017 query_found SHALL be combinational: 1 if any valid entry, including the draining head, matches query_label.
REQ-018 query_rdata SHALL be the matching entry's data, or the head entry's data when no entry matches.
REQ-019 written SHALL equal write & query_found & (hit entry is not draining). When written = 1, each byte whose query_wbe bit is 1 is replaced by query_wdata at the edge.
REQ-020 If a push merge and an accepted write target the same entry in the same cycle, the pushed data SHALL win entirely.
REQ-021 Drain state machine: WQ_IDLE -> WQ_AW when count > 0. WQ_AW -> WQ_W on awready. WQ_W -> WQ_B on wready & wlast. WQ_B -> WQ_IDLE on bvalid.
REQ-022 The head entry is marked draining from entry to WQ_AW until the pop.
REQ-023 On bvalid in WQ_B, the head SHALL be invalidated and advanced, and count decremented. A simultaneous non-merging accepted push leaves the count unchanged.
REQ-024 In WQ_AW: awvalid = 1; awaddr = {head label, LINE_BYTE_OFFSET zeros}; awlen = BURST_LIMIT; awsize = 3'b010; awburst = 2'b01 (INCR); awlock = awcache = awprot = 0; awid = AWID.
REQ-025 The beat counter SHALL be cleared in WQ_AW.
REQ-026 In WQ_W: wvalid = 1; wdata = 32-bit word [beat] of the head data, beat 0 in the least-significant bits; wstrb = 4'b1111; wid = AWID; wlast = (beat == BURST_LIMIT). The beat counter increments on wready.
REQ-027 bready SHALL be constantly 1; bresp is ignored. awvalid and wvalid SHALL be 0 in all states other than those given above.
REQ-028 Throughput: with awready, wready and bvalid each asserted on the first eligible cycle, one line SHALL retire every BURST_LIMIT + 4 cycles.

Reset
REQ-029 While rst = 0: count, head, tail, beat counter = 0; all valid bits = 0; state = WQ_IDLE.
REQ-030 Reset output values: full = 0, pushed = 0, query_found = 0, written = 0, empty = 1, awvalid = 0, wvalid = 0.
REQ-031 Reset mid-burst SHALL drop the burst and all queued entries without completing the AXI transaction.

Verification
REQ-032 Push 4 distinct labels with DEPTH = 4 and awready held 0 -> full = 1 after the 4th push; a 5th distinct push gives pushed = 0.
REQ-033 A full queue plus a push of a queued non-head label -> pushed = 1, data replaced, count stays 4.
REQ-034 Label 0x12345 queued, write = 1, query_wbe = 0x0000000F, query_wdata = all ones -> written = 1; query_rdata bytes 0-3 = 0xFF and the other bytes are unchanged.
REQ-035 Write to the draining head -> query_found = 1, written = 0; the burst data is unchanged.
REQ-036 LINE_WIDTH = 256, one line, AXI slave always ready -> awaddr = label << 5, 8 beats, wlast on beat 7; empty = 1 one cycle after bvalid.
REQ-037 Assert rst = 0 during beat 3 -> awvalid = wvalid = 0 and empty = 1 immediately, with no clock edge required.

Source files
------------

// File: rtl/axi3_wr_if.sv
// axi3_wr_if: AXI3 write address, write data and write response channels
interface axi3_wr_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awid;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic [3:0]  wid;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awid,
    input  awready,
    output wvalid, wdata, wstrb, wlast, wid,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );
endinterface

// File: rtl/write_queue.sv
// write_queue: coalescing queue of dirty cache lines drained as AXI3 INCR write bursts
module write_queue #(
  parameter int         LINE_WIDTH = 256,
  parameter int         DEPTH      = 4,
  parameter logic [3:0] AWID       = 4'd1,
  localparam int LINE_BYTE_OFFSET = $clog2(LINE_WIDTH/8),
  localparam int LABEL_WIDTH      = 32 - LINE_BYTE_OFFSET,
  localparam int BURST_LIMIT      = LINE_WIDTH/32 - 1
) (
  input  logic                              clk,
  input  logic                              rst,
  axi3_wr_if.master                         axi3_wr_if,
  input  logic [LABEL_WIDTH+LINE_WIDTH-1:0] pline,
  input  logic                              push,
  output logic                              pushed,
  output logic                              full,
  input  logic [LABEL_WIDTH-1:0]            query_label,
  output logic                              query_found,
  output logic [LINE_WIDTH-1:0]             query_rdata,
  input  logic                              write,
  input  logic [LINE_WIDTH-1:0]             query_wdata,
  input  logic [LINE_WIDTH/8-1:0]           query_wbe,
  output logic                              written,
  output logic                              empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(LINE_WIDTH/32) + 1;
  localparam logic [1:0] WQ_IDLE = 2'd0;
  localparam logic [1:0] WQ_AW   = 2'd1;
  localparam logic [1:0] WQ_W    = 2'd2;
  localparam logic [1:0] WQ_B    = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [PW:0]            count_q, count_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [LABEL_WIDTH-1:0] label_q [DEPTH];
  logic [LABEL_WIDTH-1:0] label_d [DEPTH];
  logic [LINE_WIDTH-1:0]  data_q [DEPTH];
  logic [LINE_WIDTH-1:0]  data_d [DEPTH];
  logic [PW-1:0]          q_idx, m_idx;
  logic                   m_found, draining, push_new, pop;
  logic [LABEL_WIDTH-1:0] p_label;
  logic [LINE_WIDTH-1:0]  p_data;
  logic                   unused_ok;

  assign p_label   = pline[LABEL_WIDTH+LINE_WIDTH-1:LINE_WIDTH];
  assign p_data    = pline[LINE_WIDTH-1:0];
  assign unused_ok = ^{axi3_wr_if.bresp, axi3_wr_if.bid};

  assign axi3_wr_if.awvalid = state_q == WQ_AW;
  assign axi3_wr_if.awaddr  = {label_q[head_q], LINE_BYTE_OFFSET'(0)};
  assign axi3_wr_if.awlen   = 4'(BURST_LIMIT);
  assign axi3_wr_if.awsize  = 3'b010;
  assign axi3_wr_if.awburst = 2'b01;
  assign axi3_wr_if.awlock  = 2'b00;
  assign axi3_wr_if.awcache = 4'b0000;
  assign axi3_wr_if.awprot  = 3'b000;
  assign axi3_wr_if.awid    = AWID;
  assign axi3_wr_if.wvalid  = state_q == WQ_W;
  assign axi3_wr_if.wdata   = data_q[head_q][32*beat_q +: 32];
  assign axi3_wr_if.wstrb   = 4'b1111;
  assign axi3_wr_if.wid     = AWID;
  assign axi3_wr_if.wlast   = beat_q == BW'(BURST_LIMIT);
  assign axi3_wr_if.bready  = 1'b1;

  // Lookup, merge/enqueue/update of entries, pop on response and drain sequencing
  always_comb begin
    draining    = state_q != WQ_IDLE;
    query_found = 1'b0;
    q_idx       = head_q;
    m_found     = 1'b0;
    m_idx       = head_q;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (valid_q[i] && label_q[i] == query_label) begin
        query_found = 1'b1;
        q_idx       = PW'(i);
      end
      if (valid_q[i] && label_q[i] == p_label && !(draining && PW'(i) == head_q)) begin
        m_found = 1'b1;
        m_idx   = PW'(i);
      end
    end
    query_rdata = data_q[q_idx];
    full        = count_q == (PW+1)'(DEPTH);
    empty       = count_q == '0 && !draining;
    written     = rst & write & query_found & !(draining && q_idx == head_q);
    pushed      = rst & push & (m_found | ~full);
    push_new    = push & ~m_found & ~full;
    pop         = state_q == WQ_B && axi3_wr_if.bvalid;
    valid_d     = valid_q;
    label_d     = label_q;
    data_d      = data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    for (int b = 0; b < LINE_WIDTH/8; b++)
      if (written && query_wbe[b]) data_d[q_idx][8*b +: 8] = query_wdata[8*b +: 8];
    if (push && m_found) data_d[m_idx] = p_data;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push_new) begin
      valid_d[tail_q] = 1'b1;
      label_d[tail_q] = p_label;
      data_d[tail_q]  = p_data;
      tail_d          = tail_q + 1'b1;
    end
    count_d = count_q + {{PW{1'b0}}, push_new} - {{PW{1'b0}}, pop};
    state_d = (state_q == WQ_IDLE && count_q != '0)                          ? WQ_AW   :
              (state_q == WQ_AW && axi3_wr_if.awready)                       ? WQ_W    :
              (state_q == WQ_W && axi3_wr_if.wready && axi3_wr_if.wlast)     ? WQ_B    :
              (state_q == WQ_B && axi3_wr_if.bvalid)                         ? WQ_IDLE : state_q;
    beat_d  = state_q == WQ_AW                          ? '0            :
              (state_q == WQ_W && axi3_wr_if.wready)    ? beat_q + 1'b1 : beat_q;
  end

  // Control state and valid bits, cleared asynchronously while rst is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WQ_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      beat_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  // Entry labels and data carry no reset; the valid bits qualify them
  always_ff @(posedge clk) begin
    label_q <= label_d;
    data_q  <= data_d;
  end
endmodule

// File: tb/tb_write_queue.sv
// tb_write_queue: scoreboard bench for write_queue with an always-ready AXI slave model
module tb_write_queue;
  localparam int LW  = 256;
  localparam int DEP = 4;
  localparam int LBW = 27;

  typedef struct { logic [LBW-1:0] label; logic [LW-1:0] data; } line_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              push = 1'b0;
  logic              write = 1'b0;
  logic [LBW+LW-1:0] pline = '0;
  logic [LBW-1:0]    query_label = '0;
  logic [LW-1:0]     query_wdata = '0;
  logic [LW/8-1:0]   query_wbe = '0;
  logic              pushed, full, query_found, written, empty;
  logic [LW-1:0]     query_rdata;
  int                n_cmp = 0;
  int                n_err = 0;
  int                cyc = 0;
  int                mon_beat = 0;
  int                prev_aw = 0;
  bit                tp_on = 1'b0;
  bit                prev_ok = 1'b0;
  line_t             exp_q[$];
  line_t             cur;
  logic [LBW-1:0]    lab [5];
  logic [LW-1:0]     dd [5];
  logic [LW-1:0]     merged, d_tmp;

  axi3_wr_if bus();

  write_queue #(.LINE_WIDTH(LW), .DEPTH(DEP), .AWID(4'd1)) dut (
    .clk(clk), .rst(rst), .axi3_wr_if(bus), .pline(pline), .push(push), .pushed(pushed),
    .full(full), .query_label(query_label), .query_found(query_found), .query_rdata(query_rdata),
    .write(write), .query_wdata(query_wdata), .query_wbe(query_wbe), .written(written), .empty(empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd();
    logic [LW-1:0] r;
    for (int i = 0; i < LW/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_push(input logic [LBW-1:0] l, input logic [LW-1:0] d, input logic exp_p);
    bit hit = 1'b0;
    @(negedge clk);
    push = 1'b1;
    pline = {l, d};
    #2 check("pushed", pushed, exp_p);
    @(posedge clk);
    #1 push = 1'b0;
    if (exp_p) begin
      foreach (exp_q[i]) if (exp_q[i].label == l) begin
        exp_q[i].data = d;
        hit = 1'b1;
      end
      if (!hit) exp_q.push_back('{l, d});
    end
  endtask

  task automatic do_write(input logic [LBW-1:0] l, input logic [LW-1:0] wd, input logic [LW/8-1:0] be,
                          input logic ef, input logic ew);
    @(negedge clk);
    query_label = l;
    write = 1'b1;
    query_wdata = wd;
    query_wbe = be;
    #2 check("wr_found", query_found, ef);
    check("written", written, ew);
    @(posedge clk);
    #1 write = 1'b0;
    if (ew) foreach (exp_q[i]) if (exp_q[i].label == l)
      for (int b = 0; b < LW/8; b++) if (be[b]) exp_q[i].data[8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic do_query(input logic [LBW-1:0] l, input logic ef, input logic [LW-1:0] ed);
    @(negedge clk);
    query_label = l;
    #2 check("q_found", query_found, ef);
    check("q_rdata", query_rdata, ed);
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #3;
      if (empty) break;
    end
    check("drained", empty, 1'b1);
    check("sb_left", exp_q.size(), 0);
  endtask

  // AXI slave-side monitor: pops the scoreboard on each address handshake and checks every beat
  always @(negedge clk) begin
    #2;
    if (!rst) mon_beat = 0;
    else begin
      if (bus.awvalid && bus.awready) begin
        check("aw_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check("awaddr", bus.awaddr, {cur.label, 5'b0});
          check("aw_attr", {bus.awlen, bus.awsize, bus.awburst, bus.awlock, bus.awcache, bus.awprot, bus.awid},
                {4'd7, 3'b010, 2'b01, 2'b00, 4'b0000, 3'b000, 4'd1});
        end
        mon_beat = 0;
        if (tp_on && prev_ok) check("aw_spacing", cyc - prev_aw, 11);
        prev_aw = cyc;
        prev_ok = tp_on;
      end
      if (bus.wvalid && bus.wready) begin
        check("wdata", bus.wdata, cur.data[32*mon_beat +: 32]);
        check("wlast", bus.wlast, mon_beat == 7);
        check("wstrb_wid", {bus.wstrb, bus.wid}, {4'hF, 4'd1});
        mon_beat++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.awready = 1'b0;
    bus.wready = 1'b0;
    bus.bvalid = 1'b1;
    bus.bresp = 2'b00;
    bus.bid = 4'd0;
    lab[0] = 27'h00abc; lab[1] = 27'h12345; lab[2] = 27'h00777; lab[3] = 27'h30001; lab[4] = 27'h05555;
    for (int i = 0; i < 5; i++) dd[i] = rnd();
    push = 1'b1;
    pline = {lab[0], dd[0]};
    repeat (3) @(negedge clk);
    #2 check("rst_pushed", pushed, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_found", query_found, 1'b0);
    check("rst_written", written, 1'b0);
    check("rst_valids", {bus.awvalid, bus.wvalid}, 2'b00);
    push = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_push(lab[i], dd[i], 1'b1);
      check("full_during_fill", full, i == 3);
    end
    do_push(lab[4], dd[4], 1'b0);
    check("full_hold", full, 1'b1);
    merged = rnd();
    do_push(lab[2], merged, 1'b1);
    check("full_after_merge", full, 1'b1);
    do_query(lab[2], 1'b1, merged);
    do_write(lab[1], '1, 32'h0000_000F, 1'b1, 1'b1);
    do_query(lab[1], 1'b1, {dd[1][LW-1:32], 32'hFFFF_FFFF});
    do_write(lab[0], '1, '1, 1'b1, 1'b0);
    do_query(lab[0], 1'b1, dd[0]);
    do_query(27'h7ff_ffff, 1'b0, dd[0]);
    @(negedge clk);
    tp_on = 1'b1;
    bus.awready = 1'b1;
    bus.wready = 1'b1;
    wait_empty(100);
    tp_on = 1'b0;
    d_tmp = rnd();
    do_push(27'h12345, d_tmp, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #3;
      if (bus.wvalid && bus.wlast) break;
    end
    check("saw_wlast", bus.wvalid && bus.wlast, 1'b1);
    @(negedge clk);
    #3 check("empty_in_b", empty, 1'b0);
    @(negedge clk);
    #3 check("empty_after_b", empty, 1'b1);
    query_label = lab[3];
    do_push(lab[3], rnd(), 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #3;
      if (bus.wvalid && mon_beat == 4) break;
    end
    check("at_beat3", bus.wvalid && mon_beat == 4, 1'b1);
    rst = 1'b0;
    #1 check("rstmid_valids", {bus.awvalid, bus.wvalid}, 2'b00);
    check("rstmid_empty", empty, 1'b1);
    check("rstmid_found", query_found, 1'b0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    do_push(lab[4], dd[4], 1'b1);
    wait_empty(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
